// File: rtl/jtlabrun_rom_resp_if.sv
// CPU ROM request/response and SDRAM slot signals for the main-CPU ROM responder.
// slave = the responder; master = the CPU and SDRAM controller driving it.
interface jtlabrun_rom_resp_if #(
    parameter int AW = 17
);
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic          sdram_req;
    logic [21:0]   sdram_addr;
    logic          sdram_ack;
    logic          sdram_rdy;
    logic [31:0]   data_read;

    modport slave (
        input  rom_cs, rom_addr, sdram_ack, sdram_rdy, data_read,
        output rom_data, rom_ok, sdram_req, sdram_addr
    );

    modport master (
        output rom_cs, rom_addr, sdram_ack, sdram_rdy, data_read,
        input  rom_data, rom_ok, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtlabrun_rom_resp.sv
// Main-CPU ROM responder: serves bytes from a tagged 32-bit line buffer, refilled over SDRAM req/ack/rdy.
// Latency: hit -> rom_ok one clock after the address has been stable for an edge; miss adds the SDRAM fetch.
// Backpressure: CPU stalls on rom_ok; sdram_req held until sdram_ack. JTLABRUN_ROM_2LINE_EN adds a second line.
module jtlabrun_rom_resp #(
    parameter int          AW     = 17,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic                      clk,
    input  logic                      rstn,
    jtlabrun_rom_resp_if.slave        bus
);
    localparam int TW = AW - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic          vld;
        logic [TW-1:0] tag;
        logic [31:0]   dat;
    } line_t;

    state_t        state_q, state_d;
    line_t         line0_q;
    logic [TW-1:0] cur_tag;
    logic [TW-1:0] fetch_tag_q;
    logic [21:0]   sdram_addr_q;
    logic [AW-1:0] addr_q;
    logic          rom_ok_q;
    logic [7:0]    rom_data_q;
    logic          match0;
    logic          match_any;
    logic          miss;
    logic          fetch_start;
    logic          fill;
    logic          fill0;
    logic [31:0]   sel_dat;
    line_t         fill_line;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] b);
        case (b)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    assign cur_tag   = bus.rom_addr[AW-1:2];
    assign match0    = line0_q.vld && (line0_q.tag == cur_tag);
    assign miss      = bus.rom_cs && !match_any;
    assign fill_line = '{vld: 1'b1, tag: fetch_tag_q, dat: bus.data_read};

`ifdef JTLABRUN_ROM_2LINE_EN
    line_t line1_q;
    logic  rr_q;
    logic  match1;
    logic  fill1;

    assign match1    = line1_q.vld && (line1_q.tag == cur_tag);
    assign match_any = match0 || match1;
    assign sel_dat   = match1 ? line1_q.dat : line0_q.dat;
    assign fill0     = fill && !rr_q;
    assign fill1     = fill && rr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line1_q <= '0;
            rr_q    <= 1'b0;
        end else begin
            if (fill1) begin
                line1_q <= fill_line;
            end
            if (fill) begin
                rr_q <= !rr_q;
            end
        end
    end
`else
    assign match_any = match0;
    assign sel_dat   = line0_q.dat;
    assign fill0     = fill;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ack and rdy together in REQ complete the fill without visiting WAIT
    always_comb begin
        state_d     = state_q;
        fetch_start = 1'b0;
        fill        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    fetch_start = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.sdram_ack) begin
                    if (bus.sdram_rdy) begin
                        fill    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.sdram_rdy) begin
                    fill    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line0_q      <= '0;
            fetch_tag_q  <= '0;
            sdram_addr_q <= OFFSET;
        end else begin
            if (fetch_start) begin
                fetch_tag_q  <= cur_tag;
                sdram_addr_q <= OFFSET + 22'({cur_tag, 1'b0});
            end
            if (fill0) begin
                line0_q <= fill_line;
            end
        end
    end

    // rom_ok needs the address to match the one seen on the previous edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q     <= '0;
            rom_ok_q   <= 1'b0;
            rom_data_q <= 8'h00;
        end else begin
            addr_q     <= bus.rom_addr;
            rom_ok_q   <= bus.rom_cs && match_any && (bus.rom_addr == addr_q);
            rom_data_q <= pick_byte(sel_dat, bus.rom_addr[1:0]);
        end
    end

    assign bus.sdram_req  = (state_q == ST_REQ);
    assign bus.sdram_addr = sdram_addr_q;
    assign bus.rom_ok     = rom_ok_q;
    assign bus.rom_data   = rom_data_q;

endmodule

// File: tb/tb_jtlabrun_rom_resp.sv
// Directed bench for jtlabrun_rom_resp: fills, hits, same-cycle ack/rdy, mid-fetch changes, async reset.
// Build with JTLABRUN_ROM_2LINE_EN to exercise the two-line variant.
`timescale 1ns/1ps
module tb_jtlabrun_rom_resp;
    localparam int          AW  = 17;
    localparam logic [21:0] OFF = 22'h3F8000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   passed  = 0;
    int   total   = 0;
    int   req_cnt = 0;
    int   cnt0    = 0;
    logic req_d   = 1'b0;
    logic [7:0] exp_b [3] = '{8'h22, 8'h33, 8'h44};

    jtlabrun_rom_resp_if #(.AW(AW)) bus ();

    jtlabrun_rom_resp #(.AW(AW), .OFFSET(OFF)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        req_d <= bus.sdram_req;
        if (bus.sdram_req && !req_d) req_cnt <= req_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic serve(input logic [31:0] dat, input bit same);
        int n = 0;
        while (bus.sdram_req !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check("req_seen", 32'(bus.sdram_req), 32'd1);
        bus.sdram_ack = 1'b1;
        if (same) begin
            bus.sdram_rdy = 1'b1;
            bus.data_read = dat;
        end
        step(1);
        bus.sdram_ack = 1'b0;
        if (!same) begin
            bus.sdram_rdy = 1'b1;
            bus.data_read = dat;
            step(1);
        end
        bus.sdram_rdy = 1'b0;
    endtask

    task automatic wait_ok(input string tag, input logic [7:0] exp);
        int n = 0;
        while (bus.rom_ok !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check({tag, "_ok"}, 32'(bus.rom_ok), 32'd1);
        check({tag, "_dat"}, 32'(bus.rom_data), 32'(exp));
    endtask

    initial begin
        bus.rom_cs    = 1'b0;
        bus.rom_addr  = '0;
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        bus.data_read = '0;
        step(3);
        check("rst_ok",   32'(bus.rom_ok),     32'd0);
        check("rst_dat",  32'(bus.rom_data),   32'd0);
        check("rst_req",  32'(bus.sdram_req),  32'd0);
        check("rst_addr", 32'(bus.sdram_addr), 32'(OFF));
        rstn = 1'b1;
        step(2);
        check("idle_noreq", 32'(bus.sdram_req), 32'd0);

        // first miss: ack in the first REQ cycle, rdy on the next
        bus.rom_cs   = 1'b1;
        bus.rom_addr = 17'h08000;
        step(1);
        check("a_req",  32'(bus.sdram_req),  32'd1);
        check("a_addr", 32'(bus.sdram_addr), 32'h3FC000);
        bus.sdram_ack = 1'b1;
        step(1);
        bus.sdram_ack = 1'b0;
        check("a_req_drop", 32'(bus.sdram_req), 32'd0);
        bus.sdram_rdy = 1'b1;
        bus.data_read = 32'h44332211;
        step(1);
        bus.sdram_rdy = 1'b0;
        check("a_ok_early", 32'(bus.rom_ok), 32'd0);
        step(1);
        check("a_ok",  32'(bus.rom_ok),   32'd1);
        check("a_dat", 32'(bus.rom_data), 32'h11);

        // sequential bytes of the same line
        bus.rom_addr = 17'h08001;
        step(1);
        check("b_ok_stale", 32'(bus.rom_ok), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.rom_addr = 17'h08001 + 17'(i);
            step(2);
            check("b_ok",  32'(bus.rom_ok),   32'd1);
            check("b_dat", 32'(bus.rom_data), 32'(exp_b[i]));
        end
        check("b_noreq",  32'(bus.sdram_req), 32'd0);
        check("b_reqcnt", 32'(req_cnt),       32'd1);

        // ack and rdy in the same cycle
        bus.rom_addr = 17'h00100;
        step(1);
        check("c_req",  32'(bus.sdram_req),  32'd1);
        check("c_addr", 32'(bus.sdram_addr), 32'h3F8080);
        bus.sdram_ack = 1'b1;
        bus.sdram_rdy = 1'b1;
        bus.data_read = 32'hDDCCBBAA;
        step(1);
        bus.sdram_ack = 1'b0;
        bus.sdram_rdy = 1'b0;
        check("c_req_drop", 32'(bus.sdram_req), 32'd0);
        step(1);
        check("c_ok",  32'(bus.rom_ok),   32'd1);
        check("c_dat", 32'(bus.rom_data), 32'hAA);
        step(3);
        check("c_idle",   32'(bus.sdram_req), 32'd0);
        check("c_reqcnt", 32'(req_cnt),       32'd2);

        // cs dropped and address moved while waiting for rdy
        bus.rom_addr = 17'h04000;
        step(1);
        check("d_addr", 32'(bus.sdram_addr), 32'h3FA000);
        bus.sdram_ack = 1'b1;
        step(1);
        bus.sdram_ack = 1'b0;
        bus.rom_cs    = 1'b0;
        bus.rom_addr  = 17'h0C000;
        step(2);
        check("d_ok_wait",  32'(bus.rom_ok),    32'd0);
        check("d_req_wait", 32'(bus.sdram_req), 32'd0);
        bus.sdram_rdy = 1'b1;
        bus.data_read = 32'h87654321;
        step(1);
        bus.sdram_rdy = 1'b0;
        check("d_ok_fill", 32'(bus.rom_ok), 32'd0);
        step(2);
        check("d_ok_nocs",  32'(bus.rom_ok),    32'd0);
        check("d_req_nocs", 32'(bus.sdram_req), 32'd0);
        check("d_reqcnt",   32'(req_cnt),       32'd3);
        bus.rom_cs = 1'b1;
        step(1);
        check("d_req2",  32'(bus.sdram_req),  32'd1);
        check("d_addr2", 32'(bus.sdram_addr), 32'h3FE000);
        check("d_ok2",   32'(bus.rom_ok),     32'd0);
        serve(32'hC3C2C1C0, 1'b0);
        wait_ok("d", 8'hC0);

        // wrap of the word address, then async reset while in REQ
        bus.rom_addr = 17'h1FFFF;
        step(1);
        check("e_req",  32'(bus.sdram_req),  32'd1);
        check("e_addr", 32'(bus.sdram_addr), 32'h007FFE);
        #2;
        rstn = 1'b0;
        #1;
        check("e_rst_req",  32'(bus.sdram_req),  32'd0);
        check("e_rst_ok",   32'(bus.rom_ok),     32'd0);
        check("e_rst_dat",  32'(bus.rom_data),   32'd0);
        check("e_rst_addr", 32'(bus.sdram_addr), 32'(OFF));
        bus.rom_addr = 17'h0C000;
        step(1);
        rstn = 1'b1;
        step(1);
        check("e_miss",      32'(bus.sdram_req),  32'd1);
        check("e_miss_addr", 32'(bus.sdram_addr), 32'h3FE000);
        serve(32'hC3C2C1C0, 1'b0);
        wait_ok("e", 8'hC0);

        // victim selection from a clean reset
        bus.rom_cs = 1'b0;
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        step(1);
        bus.rom_cs   = 1'b1;
        bus.rom_addr = 17'h08000;
        step(1);
        serve(32'h44332211, 1'b0);
        wait_ok("f1", 8'h11);
        bus.rom_addr = 17'h14000;
        step(1);
        check("f2_addr", 32'(bus.sdram_addr), 32'h002000);
        serve(32'hB3B2B1B0, 1'b0);
        wait_ok("f2", 8'hB0);
        step(1);
        cnt0 = req_cnt;
        bus.rom_addr = 17'h08000;
        step(3);
`ifdef JTLABRUN_ROM_2LINE_EN
        check("f3_hit_ok",  32'(bus.rom_ok),    32'd1);
        check("f3_hit_dat", 32'(bus.rom_data),  32'h11);
        check("f3_noreq",   32'(bus.sdram_req), 32'd0);
        check("f3_reqcnt",  32'(req_cnt),       32'(cnt0));
        bus.rom_addr = 17'h0C000;
        step(1);
        serve(32'hC3C2C1C0, 1'b0);
        wait_ok("f4", 8'hC0);
        bus.rom_addr = 17'h14000;
        step(3);
        check("f5_keep_ok",  32'(bus.rom_ok),   32'd1);
        check("f5_keep_dat", 32'(bus.rom_data), 32'hB0);
        bus.rom_addr = 17'h08000;
        step(1);
        check("f6_evicted", 32'(bus.sdram_req), 32'd1);
        serve(32'h44332211, 1'b0);
        wait_ok("f6", 8'h11);
`else
        check("f3_miss", 32'(bus.sdram_req), 32'd1);
        serve(32'h44332211, 1'b0);
        wait_ok("f3", 8'h11);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
